// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - match sequencer for N-player Pong: game tick, scores, pause, serve delay, winner hold
//
// Ports:
//   clock_i         system clock
//   reset_i         synchronous, active-high reset
//   pause_i         level; freezes PLAY and POINT
//   serve_i         level; starts a match from IDLE
//   scored_i        one-clock pulse per bit, bit i = player i scored
//   game_tick_o     one-clock enable at TICK_RATE while in PLAY
//   round_reset_o   one-clock pulse; ball returns to centre
//   score_update_o  one-clock pulse after the scores register changes
//   scores_o        player i at [i*SCORE_WIDTH +: SCORE_WIDTH]
//   winner_o        one-hot match winner, 0 when no winner
//   state_o         IDLE=0 PLAY=1 PAUSED=2 POINT=3 WIN_HOLD=4
module pong_match_ctrl #(
    parameter int CLOCK_FREQ   = 50000000,
    parameter int TICK_RATE    = 50,
    parameter int N_PLAYERS    = 2,
    parameter int SCORE_WIDTH  = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_CYCLES = 25000000,
    parameter int HOLD_CYCLES  = 350000000
) (
    input  logic                             clock_i,
    input  logic                             reset_i,
    input  logic                             pause_i,
    input  logic                             serve_i,
    input  logic [N_PLAYERS-1:0]             scored_i,
    output logic                             game_tick_o,
    output logic                             round_reset_o,
    output logic                             score_update_o,
    output logic [N_PLAYERS*SCORE_WIDTH-1:0] scores_o,
    output logic [N_PLAYERS-1:0]             winner_o,
    output logic [2:0]                       state_o
);

    localparam int DIV    = CLOCK_FREQ / TICK_RATE;
    localparam int TICK_W = $clog2(DIV);
    localparam int SW     = N_PLAYERS * SCORE_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLAY     = 3'd1,
        S_PAUSED   = 3'd2,
        S_POINT    = 3'd3,
        S_WIN_HOLD = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [TICK_W-1:0]        tick_cnt_q, tick_cnt_d;
    logic [31:0]              serve_cnt_q, serve_cnt_d;
    logic [31:0]              hold_cnt_q, hold_cnt_d;
    logic [SW-1:0]            scores_q, scores_d;
    logic [N_PLAYERS-1:0]     winner_q, winner_d;
    logic                     game_tick_q, game_tick_d;
    logic                     round_reset_q, round_reset_d;
    logic                     score_update_q, score_update_d;

    // Scorer selection: lowest-index set bit wins, others are dropped.
    int                       scorer_idx;
    logic                     scorer_hit;
    logic [SCORE_WIDTH-1:0]   new_score;

    always_comb begin
        scorer_idx = 0;
        scorer_hit = |scored_i;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (scored_i[i]) begin
                scorer_idx = i;
            end
        end
        new_score = scores_q[scorer_idx*SCORE_WIDTH +: SCORE_WIDTH] + SCORE_WIDTH'(1);
    end

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        serve_cnt_d   = '0;
        hold_cnt_d    = '0;
        scores_d      = scores_q;
        winner_d      = winner_q;
        game_tick_d   = 1'b0;
        round_reset_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                scores_d   = '0;
                winner_d   = '0;
                tick_cnt_d = '0;
                if (serve_i) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                // Pause wins over a simultaneous score; the divider does not
                // advance in the pausing cycle so the tick phase is preserved.
                if (pause_i) begin
                    state_d = S_PAUSED;
                end else begin
                    if (tick_cnt_q == TICK_W'(DIV - 1)) begin
                        tick_cnt_d  = '0;
                        game_tick_d = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                    if (scorer_hit) begin
                        scores_d[scorer_idx*SCORE_WIDTH +: SCORE_WIDTH] = new_score;
                        if (new_score == SCORE_WIDTH'(WIN_SCORE)) begin
                            state_d  = S_WIN_HOLD;
                            winner_d = N_PLAYERS'(1) << scorer_idx;
                        end else begin
                            state_d       = S_POINT;
                            round_reset_d = 1'b1;
                        end
                    end
                end
            end
            S_PAUSED: begin
                if (!pause_i) begin
                    state_d = S_PLAY;
                end
            end
            S_POINT: begin
                if (pause_i) begin
                    serve_cnt_d = serve_cnt_q;
                end else if (serve_cnt_q == 32'(SERVE_CYCLES - 1)) begin
                    state_d    = S_PLAY;
                    tick_cnt_d = '0;
                end else begin
                    serve_cnt_d = serve_cnt_q + 32'd1;
                end
            end
            S_WIN_HOLD: begin
                if (hold_cnt_q == 32'(HOLD_CYCLES - 1)) begin
                    state_d       = S_IDLE;
                    scores_d      = '0;
                    winner_d      = '0;
                    round_reset_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        score_update_d = (scores_d != scores_q);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            tick_cnt_q     <= '0;
            serve_cnt_q    <= '0;
            hold_cnt_q     <= '0;
            scores_q       <= '0;
            winner_q       <= '0;
            game_tick_q    <= 1'b0;
            round_reset_q  <= 1'b0;
            score_update_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            serve_cnt_q    <= serve_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            scores_q       <= scores_d;
            winner_q       <= winner_d;
            game_tick_q    <= game_tick_d;
            round_reset_q  <= round_reset_d;
            score_update_q <= score_update_d;
        end
    end

    assign game_tick_o    = game_tick_q;
    assign round_reset_o  = round_reset_q;
    assign score_update_o = score_update_q;
    assign scores_o       = scores_q;
    assign winner_o       = winner_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - directed self-checking bench for pong_match_ctrl
module tb_pong_match_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        pause;
    logic        serve;
    logic [2:0]  scored;
    logic        game_tick;
    logic        round_reset;
    logic        score_update;
    logic [11:0] scores;
    logic [2:0]  winner;
    logic [2:0]  state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pong_match_ctrl #(
        .CLOCK_FREQ  (20),
        .TICK_RATE   (2),
        .N_PLAYERS   (3),
        .SCORE_WIDTH (4),
        .WIN_SCORE   (3),
        .SERVE_CYCLES(5),
        .HOLD_CYCLES (30)
    ) dut (
        .clock_i       (clk),
        .reset_i       (reset),
        .pause_i       (pause),
        .serve_i       (serve),
        .scored_i      (scored),
        .game_tick_o   (game_tick),
        .round_reset_o (round_reset),
        .score_update_o(score_update),
        .scores_o      (scores),
        .winner_o      (winner),
        .state_o       (state)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_scores"}, 32'(scores), 32'd0);
        chk({tag, "_winner"}, 32'(winner), 32'd0);
        chk({tag, "_tick"}, 32'(game_tick), 32'd0);
        chk({tag, "_rr"}, 32'(round_reset), 32'd0);
        chk({tag, "_su"}, 32'(score_update), 32'd0);
    endtask

    task automatic score_point(input logic [2:0] v);
        scored = v;
        cyc();
        scored = 3'b000;
    endtask

    initial begin
        reset  = 1'b1;
        pause  = 1'b0;
        serve  = 1'b0;
        scored = 3'b000;
        cyc();
        cyc();
        chk_reset_vals("reset");
        reset = 1'b0;

        // 1: no ticks in IDLE, then serve and tick every 10 cycles
        for (int i = 1; i <= 15; i++) begin
            cyc();
            chk("idle_tick", 32'(game_tick), 32'd0);
        end
        chk("idle_state", 32'(state), 32'd0);
        serve = 1'b1;
        cyc();
        serve = 1'b0;
        chk("serve_state", 32'(state), 32'd1);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            chk("play_tick", 32'(game_tick), 32'((i == 10) || (i == 20)));
        end

        // 2: pause after 4 PLAY cycles keeps tick phase
        repeat (4) begin
            cyc();
            chk("pre_pause_tick", 32'(game_tick), 32'd0);
        end
        pause = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            chk("paused_state", 32'(state), 32'd2);
            chk("paused_tick", 32'(game_tick), 32'd0);
        end
        pause = 1'b0;
        cyc();
        chk("resume_state", 32'(state), 32'd1);
        for (int j = 1; j <= 6; j++) begin
            cyc();
            chk("resume_tick", 32'(game_tick), 32'(j == 6));
        end

        // 3: simultaneous scorers, lowest index wins; serve delay
        score_point(3'b110);
        chk("pt_state", 32'(state), 32'd3);
        chk("pt_scores", 32'(scores), 32'h010);
        chk("pt_rr", 32'(round_reset), 32'd1);
        chk("pt_su", 32'(score_update), 32'd1);
        scored = 3'b001;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("pt_hold_state", 32'(state), 32'd3);
            chk("pt_hold_rr", 32'(round_reset), 32'd0);
            chk("pt_hold_su", 32'(score_update), 32'd0);
            chk("pt_ignore_scored", 32'(scores), 32'h010);
        end
        scored = 3'b000;
        cyc();
        chk("pt_exit_state", 32'(state), 32'd1);

        // 4: player2 wins, timed hold, then restart
        score_point(3'b100);
        chk("p2a_scores", 32'(scores), 32'h110);
        chk("p2a_state", 32'(state), 32'd3);
        repeat (5) cyc();
        chk("p2a_play", 32'(state), 32'd1);
        score_point(3'b100);
        chk("p2b_scores", 32'(scores), 32'h210);
        repeat (5) cyc();
        chk("p2b_play", 32'(state), 32'd1);
        score_point(3'b100);
        chk("win_state", 32'(state), 32'd4);
        chk("win_winner", 32'(winner), 32'b100);
        chk("win_scores", 32'(scores), 32'h310);
        chk("win_rr", 32'(round_reset), 32'd0);
        pause  = 1'b1;
        scored = 3'b001;
        for (int i = 1; i <= 29; i++) begin
            cyc();
            chk("hold_state", 32'(state), 32'd4);
            chk("hold_tick", 32'(game_tick), 32'd0);
        end
        chk("hold_winner", 32'(winner), 32'b100);
        chk("hold_scores", 32'(scores), 32'h310);
        pause  = 1'b0;
        scored = 3'b000;
        cyc();
        chk("end_state", 32'(state), 32'd0);
        chk("end_scores", 32'(scores), 32'd0);
        chk("end_winner", 32'(winner), 32'd0);
        chk("end_rr", 32'(round_reset), 32'd1);
        cyc();
        chk("end_rr_drop", 32'(round_reset), 32'd0);

        // 5: pause beats scored in the same cycle
        serve = 1'b1;
        cyc();
        serve = 1'b0;
        chk("m2_state", 32'(state), 32'd1);
        pause  = 1'b1;
        scored = 3'b001;
        cyc();
        scored = 3'b000;
        chk("pause_pri_state", 32'(state), 32'd2);
        chk("pause_pri_scores", 32'(scores), 32'd0);
        chk("pause_pri_su", 32'(score_update), 32'd0);
        cyc();
        chk("pause_pri_hold", 32'(state), 32'd2);

        // 6a: reset in PAUSED
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        pause = 1'b0;
        chk_reset_vals("rst_paused");

        // 6b: reset in WIN_HOLD
        serve = 1'b1;
        cyc();
        serve = 1'b0;
        score_point(3'b001);
        repeat (5) cyc();
        score_point(3'b001);
        repeat (5) cyc();
        score_point(3'b001);
        chk("p0_win_state", 32'(state), 32'd4);
        chk("p0_win_winner", 32'(winner), 32'b001);
        chk("p0_win_scores", 32'(scores), 32'h003);
        repeat (5) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_reset_vals("rst_hold");

        // 6c: fresh match after reset, pause stretches serve delay
        serve = 1'b1;
        cyc();
        serve = 1'b0;
        chk("m3_state", 32'(state), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk("m3_tick", 32'(game_tick), 32'(i == 10));
        end
        score_point(3'b010);
        chk("m3_scores", 32'(scores), 32'h010);
        chk("m3_state_pt", 32'(state), 32'd3);
        pause = 1'b1;
        repeat (3) cyc();
        pause = 1'b0;
        repeat (4) begin
            cyc();
            chk("m3_pt_paused", 32'(state), 32'd3);
        end
        cyc();
        chk("m3_pt_exit", 32'(state), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
